// File: rtl/muldiv_pkg.sv
// Shared types and opcodes for the iterative multiply/divide sequencer.
package muldiv_pkg;

    typedef enum logic [1:0] {IDLE, RUN, DONE} muldiv_state_t;

    localparam logic OP_MUL = 1'b0;
    localparam logic OP_DIV = 1'b1;

endpackage

// File: rtl/muldiv_seq_addsub.sv
// N-bit adder/subtractor; FlagC is the carry out, i.e. 1 = no borrow when subtracting.
module addsub #(
    parameter int N = 32
) (
    input  logic [N-1:0] A,
    input  logic [N-1:0] B,
    input  logic         Subtract,
    output logic [N-1:0] Result,
    output logic         FlagC,
    output logic         FlagN,
    output logic         FlagV
);

    logic [N-1:0] b_eff;

    assign b_eff = B ^ {N{Subtract}};
    assign {FlagC, Result} = {1'b0, A} + {1'b0, b_eff} + {{N{1'b0}}, Subtract};
    assign FlagN = Result[N-1];
    assign FlagV = (A[N-1] == b_eff[N-1]) && (Result[N-1] != A[N-1]);

endmodule

// File: rtl/muldiv_seq.sv
// Iterative unsigned shift-add multiply / restoring divide over one shared addsub.
// Optional MULDIV_ABORT_EN adds an Abort input that cancels a running operation.
//
// state | meaning
// IDLE  | waiting for Start
// RUN   | one iteration per edge, Busy = 1
// DONE  | single cycle, Done = 1, results valid
module muldiv_seq
    import muldiv_pkg::*;
#(
    parameter int N = 32
) (
    input  logic         clock,
    input  logic         reset_n,
    input  logic         Start,
    input  logic         Op,
    input  logic [N-1:0] A,
    input  logic [N-1:0] B,
`ifdef MULDIV_ABORT_EN
    input  logic         Abort,
`endif
    output logic         Busy,
    output logic         Done,
    output logic [N-1:0] Hi,
    output logic [N-1:0] Lo,
    output logic         DivByZero
);

    localparam int CNT_W = $clog2(N);

    muldiv_state_t state, state_next;
    logic [CNT_W-1:0] cnt;
    logic             op_reg;
    logic [N-1:0]     b_reg;
    logic             accept, abort, div_zero;

    logic [N-1:0] add_a, add_result, mul_sum, rem_shift;
    logic         add_c, mul_carry, quo_bit;
    logic         unused_flag_n, unused_flag_v;

`ifdef MULDIV_ABORT_EN
    assign abort = Abort && (state == RUN);
`else
    assign abort = 1'b0;
`endif

    assign accept   = Start && (state != RUN);
    assign div_zero = (op_reg == OP_DIV) && (b_reg == '0);

    // Divide computes R' - D; multiply adds the multiplicand into Hi.
    assign rem_shift = {Hi[N-2:0], Lo[N-1]};
    assign add_a     = (op_reg == OP_MUL) ? Hi : rem_shift;

    addsub #(.N(N)) u_addsub (
        .A        (add_a),
        .B        (b_reg),
        .Subtract (op_reg),
        .Result   (add_result),
        .FlagC    (add_c),
        .FlagN    (unused_flag_n),
        .FlagV    (unused_flag_v)
    );

    assign mul_sum   = Lo[0] ? add_result : Hi;
    assign mul_carry = Lo[0] & add_c;
    assign quo_bit   = Hi[N-1] | add_c;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: if (Start) state_next = RUN;
            RUN: begin
                if (abort) begin
                    state_next = IDLE;
                end else if (div_zero || cnt == '0) begin
                    state_next = DONE;
                end
            end
            DONE:    state_next = Start ? RUN : IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            cnt       <= '0;
            op_reg    <= OP_MUL;
            b_reg     <= '0;
            Hi        <= '0;
            Lo        <= '0;
            DivByZero <= 1'b0;
        end else if (accept) begin
            cnt       <= CNT_W'(N - 1);
            op_reg    <= Op;
            b_reg     <= B;
            Hi        <= '0;
            Lo        <= A;
            DivByZero <= 1'b0;
        end else if (state == RUN && !abort) begin
            cnt <= cnt - CNT_W'(1);
            if (div_zero) begin
                Hi        <= Lo;
                Lo        <= '1;
                DivByZero <= 1'b1;
            end else if (op_reg == OP_MUL) begin
                Hi <= {mul_carry, mul_sum[N-1:1]};
                Lo <= {mul_sum[0], Lo[N-1:1]};
            end else begin
                Hi <= quo_bit ? add_result : rem_shift;
                Lo <= {Lo[N-2:0], quo_bit};
            end
        end
    end

    assign Busy = (state == RUN);
    assign Done = (state == DONE);

endmodule

// File: tb/tb_muldiv_seq.sv
// Randomized and directed checks of muldiv_seq (N = 8) against an arithmetic reference model.
module tb_muldiv_seq;

    localparam int N = 8;

    logic         clock;
    logic         reset_n;
    logic         Start;
    logic         Op;
    logic [N-1:0] A;
    logic [N-1:0] B;
    logic         Busy;
    logic         Done;
    logic [N-1:0] Hi;
    logic [N-1:0] Lo;
    logic         DivByZero;

    int compared   = 0;
    int mismatched = 0;

    muldiv_seq #(.N(N)) dut (
        .clock     (clock),
        .reset_n   (reset_n),
        .Start     (Start),
        .Op        (Op),
        .A         (A),
        .B         (B),
`ifdef MULDIV_ABORT_EN
        .Abort     (1'b0),
`endif
        .Busy      (Busy),
        .Done      (Done),
        .Hi        (Hi),
        .Lo        (Lo),
        .DivByZero (DivByZero)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: timeline and results from plain arithmetic.
    bit           m_busy  = 0;
    bit           m_done  = 0;
    bit           m_dz    = 0;
    bit           m_valid = 1;
    int           m_left  = 0;
    logic [N-1:0] m_hi    = '0;
    logic [N-1:0] m_lo    = '0;
    logic [N-1:0] p_hi, p_lo;
    bit           p_dz;

    always @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            m_busy = 0; m_done = 0; m_dz = 0; m_valid = 1; m_left = 0;
            m_hi = '0; m_lo = '0;
        end else begin
            m_done = 0;
            if (!m_busy && Start) begin
                logic [2*N-1:0] prod;
                m_busy = 1; m_dz = 0; m_valid = 0;
                if (Op == 1'b0) begin
                    prod = A * B;
                    p_hi = prod[2*N-1:N]; p_lo = prod[N-1:0]; p_dz = 0;
                    m_left = N;
                end else if (B == '0) begin
                    p_hi = A; p_lo = '1; p_dz = 1;
                    m_left = 1;
                end else begin
                    p_hi = A % B; p_lo = A / B; p_dz = 0;
                    m_left = N;
                end
            end else if (m_busy) begin
                m_left--;
                if (m_left == 0) begin
                    m_busy = 0; m_done = 1; m_valid = 1;
                    m_hi = p_hi; m_lo = p_lo; m_dz = p_dz;
                end
            end
        end
    end

    always @(negedge clock) begin
        check("busy", {31'b0, Busy}, {31'b0, m_busy});
        check("done", {31'b0, Done}, {31'b0, m_done});
        check("div_by_zero", {31'b0, DivByZero}, {31'b0, m_dz});
        if (m_valid) begin
            check("hi", {24'b0, Hi}, {24'b0, m_hi});
            check("lo", {24'b0, Lo}, {24'b0, m_lo});
        end
    end

    // Drives one request now (at a negedge) and waits, bounded, for Done.
    task automatic run_op(input logic op, input logic [N-1:0] a, input logic [N-1:0] b,
                          input int glitch_at, input bit rand_glitch,
                          output int lat, output int busy_cnt);
        Start = 1'b1; Op = op; A = a; B = b;
        lat = 0; busy_cnt = 0;
        for (int i = 1; i <= 40; i++) begin
            @(negedge clock);
            Start = 1'b0;
            if (Done) begin
                lat = i;
                break;
            end
            if (Busy) busy_cnt++;
            if (Busy && (i == glitch_at || (rand_glitch && $urandom_range(0, 3) == 0))) begin
                Start = 1'b1; Op = 1'($urandom); A = N'($urandom); B = N'($urandom);
            end
        end
        if (lat == 0) check("done_timeout", 32'd0, 32'd1);
    endtask

    int lat, bcnt;

    initial begin
        reset_n = 1'b0; Start = 1'b0; Op = 1'b0; A = '0; B = '0;
        repeat (2) @(negedge clock);
        check("rst_hi", {24'b0, Hi}, 32'h0);
        check("rst_lo", {24'b0, Lo}, 32'h0);
        check("rst_busy", {31'b0, Busy}, 32'h0);
        reset_n = 1'b1;
        @(negedge clock);

        run_op(1'b0, 8'd13, 8'd11, 0, 0, lat, bcnt);
        check("mul13x11_lat", lat, N + 1);
        check("mul13x11_busy_cycles", bcnt, N);
        check("mul13x11_hi", {24'b0, Hi}, 32'h00);
        check("mul13x11_lo", {24'b0, Lo}, 32'h8F);
        @(negedge clock);

        run_op(1'b0, 8'd255, 8'd255, 0, 0, lat, bcnt);
        check("mul255x255_hi", {24'b0, Hi}, 32'hFE);
        check("mul255x255_lo", {24'b0, Lo}, 32'h01);
        @(negedge clock);

        run_op(1'b1, 8'd200, 8'd7, 0, 0, lat, bcnt);
        check("div200by7_lo", {24'b0, Lo}, 32'h1C);
        check("div200by7_hi", {24'b0, Hi}, 32'h04);
        check("div200by7_dz", {31'b0, DivByZero}, 32'h0);
        @(negedge clock);

        run_op(1'b1, 8'd5, 8'd0, 0, 0, lat, bcnt);
        check("div5by0_lat", lat, 2);
        check("div5by0_lo", {24'b0, Lo}, 32'hFF);
        check("div5by0_hi", {24'b0, Hi}, 32'h05);
        check("div5by0_dz", {31'b0, DivByZero}, 32'h1);
        @(negedge clock);

        run_op(1'b0, 8'd2, 8'd3, 0, 0, lat, bcnt);
        check("mul2x3_dz", {31'b0, DivByZero}, 32'h0);
        check("mul2x3_lo", {24'b0, Lo}, 32'h06);
        @(negedge clock);

        run_op(1'b0, 8'd13, 8'd11, 3, 0, lat, bcnt);
        check("ignored_start_lo", {24'b0, Lo}, 32'h8F);
        check("ignored_start_hi", {24'b0, Hi}, 32'h00);
        run_op(1'b1, 8'd255, 8'd1, 0, 0, lat, bcnt);
        check("b2b_lat", lat, N + 1);
        check("b2b_lo", {24'b0, Lo}, 32'hFF);
        check("b2b_hi", {24'b0, Hi}, 32'h00);
        @(negedge clock);

        // Reset in the middle of a multiply.
        Start = 1'b1; Op = 1'b0; A = 8'd255; B = 8'd255;
        @(negedge clock);
        Start = 1'b0;
        repeat (3) @(negedge clock);
        #2 reset_n = 1'b0;
        #1;
        check("midrst_busy", {31'b0, Busy}, 32'h0);
        check("midrst_done", {31'b0, Done}, 32'h0);
        check("midrst_hi", {24'b0, Hi}, 32'h0);
        check("midrst_lo", {24'b0, Lo}, 32'h0);
        check("midrst_dz", {31'b0, DivByZero}, 32'h0);
        @(negedge clock);
        reset_n = 1'b1;
        repeat (2) @(negedge clock);
        check("after_rst_busy", {31'b0, Busy}, 32'h0);

        for (int k = 0; k < 200; k++) begin
            logic [N-1:0] rb;
            rb = ($urandom_range(0, 7) == 0) ? '0 : N'($urandom);
            run_op(1'($urandom), N'($urandom), rb, 0, 1, lat, bcnt);
            repeat ($urandom_range(0, 2)) @(negedge clock);
        end
        repeat (3) @(negedge clock);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
